// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: merges WB-stage and multi-cycle-unit writes onto one registered GRF write port, WB first.
// Latency: WB 1 cycle; md >= 2 cycles through a 2-entry queue (1 cycle when idle with GRF_ARB_MD_BYPASS_EN).
// Backpressure: WB never stalled; md_ready low and stall_req high while the queue is full.
module grf_write_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        md_valid,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        md_ready,
    output logic        grf_we,
    output logic [4:0]  grf_addr,
    output logic [31:0] grf_data,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        q_busy,
    output logic        stall_req
);
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] dat;
    } wr_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} cnt_e;

    cnt_e       cnt_q, cnt_d;
    wr_t        ent0_q, ent0_d, ent1_q, ent1_d;
    wr_t        grf_q, grf_d;
    logic       grf_we_q, grf_we_d;
    logic       wb_vld, md_acc, md_vld, bypass, pop, push, keep0, keep1;
    logic [1:0] n;
    wr_t        md_ent;

    function automatic logic hit(input logic [4:0] a, input logic [4:0] s1, input logic [4:0] s2);
        return (a != 5'd0) && ((a == s1) || (a == s2));
    endfunction

    always_comb begin
        wb_vld   = wb_we && (wb_addr != 5'd0);
        md_ready = (cnt_q != FULL);
        md_acc   = md_valid && md_ready;
        md_vld   = md_acc && (md_addr != 5'd0);
        md_ent   = '{addr: md_addr, dat: md_data};
`ifdef GRF_ARB_MD_BYPASS_EN
        bypass   = md_vld && !wb_vld && (cnt_q == EMPTY);
`else
        bypass   = 1'b0;
`endif
        pop      = !wb_vld && (cnt_q != EMPTY);
        push     = md_vld && !bypass;
        stall_req = (cnt_q == FULL);
        q_busy   = ((cnt_q != EMPTY) && hit(ent0_q.addr, q_addr1, q_addr2)) ||
                   ((cnt_q == FULL)  && hit(ent1_q.addr, q_addr1, q_addr2)) ||
                   (md_acc && hit(md_addr, q_addr1, q_addr2));
    end

    // A WB write to a queued address supersedes the older queued value, so drop it.
    always_comb begin
        keep0  = (cnt_q != EMPTY) && !pop && !(wb_vld && (ent0_q.addr == wb_addr));
        keep1  = (cnt_q == FULL) && !(wb_vld && (ent1_q.addr == wb_addr));
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        n      = 2'd0;
        if (keep0) begin
            n = 2'd1;
        end
        if (keep1) begin
            if (keep0) begin
                ent1_d = ent1_q;
            end else begin
                ent0_d = ent1_q;
            end
            n = n + 2'd1;
        end
        if (push) begin
            if (n == 2'd0) begin
                ent0_d = md_ent;
            end else begin
                ent1_d = md_ent;
            end
            n = n + 2'd1;
        end
        cnt_d = cnt_e'(n);
    end

    always_comb begin
        grf_we_d = 1'b0;
        grf_d    = grf_q;
        if (wb_vld) begin
            grf_we_d = 1'b1;
            grf_d    = '{addr: wb_addr, dat: wb_data};
        end else if (bypass) begin
            grf_we_d = 1'b1;
            grf_d    = md_ent;
        end else if (pop) begin
            grf_we_d = 1'b1;
            grf_d    = ent0_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= EMPTY;
            ent0_q   <= '0;
            ent1_q   <= '0;
            grf_we_q <= 1'b0;
            grf_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ent0_q   <= ent0_d;
            ent1_q   <= ent1_d;
            grf_we_q <= grf_we_d;
            grf_q    <= grf_d;
        end
    end

    assign grf_we   = grf_we_q;
    assign grf_addr = grf_q.addr;
    assign grf_data = grf_q.dat;
endmodule
